// File: rtl/bram_dp_responder.sv
// True dual-port block RAM with a post-reset clear sweep, registered reads,
// defined same-address collision handling and a saturating committed-write counter.
module bram_dp_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  we_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  ready,
  output logic                  collision,
  output logic [15:0]           wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] clr_ptr_odd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  serving;
  logic                  same_addr;
  logic                  dual_same_write;
  logic                  clr_last;
  logic [1:0]            wr_inc;
  logic [16:0]           wr_sum;

  always_comb begin
    serving         = (state == READY);
    same_addr       = (addr_a == addr_b);
    dual_same_write = we_a && we_b && same_addr;
    clr_ptr_odd     = clr_ptr | ADDR_WIDTH'(1);
    clr_last        = (clr_ptr == ADDR_WIDTH'(DEPTH - 2));
    wr_inc          = '0;
    if (serving) begin
      if (dual_same_write) wr_inc = 2'd1;
      else                 wr_inc = {1'b0, we_a} + {1'b0, we_b};
    end
    wr_sum = {1'b0, wr_count} + 17'(wr_inc);
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_last) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  assign ready = serving;

  // Array has no reset; the sweep is held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (!serving) begin
      if (reset) begin
        mem[clr_ptr]     <= '0;
        mem[clr_ptr_odd] <= '0;
      end
    end else begin
      if (we_b && !dual_same_write) mem[addr_b] <= data_b;
      if (we_a)                     mem[addr_a] <= data_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_ptr   <= '0;
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
      wr_count  <= '0;
    end else if (!serving) begin
      clr_ptr   <= clr_ptr + ADDR_WIDTH'(2);
      q_a       <= '0;
      q_b       <= '0;
      collision <= 1'b0;
    end else begin
      q_a       <= we_a ? data_a : mem[addr_a];
      // Port A wins a same-address dual write, so B reflects A's data.
      if (we_b) q_b <= dual_same_write ? data_a : data_b;
      else      q_b <= mem[addr_b];
      collision <= same_addr && (we_a || we_b);
      wr_count  <= wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
    end
  end

endmodule

// File: tb/tb_bram_dp_responder.sv
// Directed bench for bram_dp_responder: expected port results are queued at drive
// time and popped/compared after the clock edge that produces them.
module tb_bram_dp_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [15:0] q_a, q_b, wr_count;
  logic        ready, collision;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] qa;
    logic [15:0] qb;
    logic        col;
  } exp_t;

  exp_t sb[$];

  bram_dp_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b),
    .q_a(q_a), .q_b(q_b), .ready(ready),
    .collision(collision), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One serviced cycle: drive, queue expectation, clock, pop and compare.
  task automatic step(input string tag,
                      input logic wa, input logic [9:0] aa, input logic [15:0] da,
                      input logic wb, input logic [9:0] ab, input logic [15:0] db,
                      input logic [15:0] eqa, input logic [15:0] eqb, input logic ecol);
    exp_t e;
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    sb.push_back('{tag, eqa, eqb, ecol});
    @(posedge clk); #1;
    we_a = 1'b0; we_b = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_qa"}, 32'(q_a), 32'(e.qa));
    chk({e.tag, "_qb"}, 32'(q_b), 32'(e.qb));
    chk({e.tag, "_col"}, 32'(collision), 32'(e.col));
  endtask

  // Releases reset and counts posedges until ready, with clear-time writes presented.
  task automatic release_and_sweep(input string tag, input logic [15:0] junk);
    int unsigned cycles;
    cycles = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    we_a = 1'b1; addr_a = 10'd0; data_a = junk;
    we_b = 1'b1; addr_b = 10'd1; data_b = ~junk;
    while (!ready && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (!ready && cycles == 300) chk({tag, "_mid_qa"}, 32'(q_a), 32'h0);
    end
    we_a = 1'b0; we_b = 1'b0;
    chk({tag, "_cycles"}, 32'(cycles), 32'd512);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_qa", 32'(q_a), 32'h0);
    chk("rst_qb", 32'(q_b), 32'h0);
    chk("rst_col", 32'(collision), 32'h0);
    chk("rst_wr", 32'(wr_count), 32'h0);

    release_and_sweep("sweep1", 16'hBEEF);

    step("rd_0_1",     0, 10'd0,   16'h0, 0, 10'd1,   16'h0, 16'h0000, 16'h0000, 1'b0);
    step("rd_510_511", 0, 10'd510, 16'h0, 0, 10'd511, 16'h0, 16'h0000, 16'h0000, 1'b0);
    chk("wr_after_clear", 32'(wr_count), 32'h0);

    step("wr_0_1",  1, 10'd0, 16'h0008, 1, 10'd1, 16'h000A, 16'h0008, 16'h000A, 1'b0);
    step("rd2_0_1", 0, 10'd0, 16'h0,    0, 10'd1, 16'h0,    16'h0008, 16'h000A, 1'b0);
    chk("wr_cnt2", 32'(wr_count), 32'd2);

    step("ow_0_1",      1, 10'd0,   16'h0009, 1, 10'd1,   16'h000B, 16'h0009, 16'h000B, 1'b0);
    step("wr_510_511",  1, 10'd510, 16'h0020, 1, 10'd511, 16'h0012, 16'h0020, 16'h0012, 1'b0);
    step("rd3_0_1",     0, 10'd0,   16'h0,    0, 10'd1,   16'h0,    16'h0009, 16'h000B, 1'b0);
    step("rd3_510_511", 0, 10'd510, 16'h0,    0, 10'd511, 16'h0,    16'h0020, 16'h0012, 1'b0);
    chk("wr_cnt6", 32'(wr_count), 32'd6);

    step("dual_wr5", 1, 10'd5, 16'h1111, 1, 10'd5, 16'h2222, 16'h1111, 16'h1111, 1'b1);
    step("rd_5",     0, 10'd5, 16'h0,    0, 10'd5, 16'h0,    16'h1111, 16'h1111, 1'b0);
    chk("wr_cnt7", 32'(wr_count), 32'd7);

    step("wr7_3",    1, 10'd7, 16'h0003, 0, 10'd0, 16'h0,    16'h0003, 16'h0009, 1'b0);
    step("a_wr_b_rd7", 1, 10'd7, 16'h00FF, 0, 10'd7, 16'h0, 16'h00FF, 16'h0003, 1'b1);
    step("rd_6_7",   0, 10'd6, 16'h0,    0, 10'd7, 16'h0,    16'h0000, 16'h00FF, 1'b0);
    step("b_wr_a_rd7", 0, 10'd7, 16'h0, 1, 10'd7, 16'hABCD, 16'h00FF, 16'hABCD, 1'b1);
    step("rd_7",     0, 10'd7, 16'h0,    0, 10'd7, 16'h0,    16'hABCD, 16'hABCD, 1'b0);
    chk("wr_cnt10", 32'(wr_count), 32'd10);

    // Asynchronous reset mid-service, between clock edges
    #2 reset = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'h0);
    chk("arst_qa", 32'(q_a), 32'h0);
    chk("arst_qb", 32'(q_b), 32'h0);
    chk("arst_wr", 32'(wr_count), 32'h0);

    // Reset asserted 100 cycles into the sweep
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("sweep_rst_ready", 32'(ready), 32'h0);
    chk("sweep_rst_wr", 32'(wr_count), 32'h0);
    release_and_sweep("sweep2", 16'h5555);
    step("rd_after_sweep2", 0, 10'd0, 16'h0, 0, 10'd7, 16'h0, 16'h0000, 16'h0000, 1'b0);

    // Saturation of the write counter
    we_a = 1'b1; addr_a = 10'd2; data_a = 16'h0042;
    we_b = 1'b1; addr_b = 10'd3; data_b = 16'h0043;
    repeat (32767) @(posedge clk);
    #1;
    chk("wr_cnt_fffe", 32'(wr_count), 32'hFFFE);
    @(posedge clk); #1;
    chk("wr_cnt_sat", 32'(wr_count), 32'hFFFF);
    we_b = 1'b0;
    @(posedge clk); #1;
    chk("wr_cnt_hold", 32'(wr_count), 32'hFFFF);
    we_a = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
